// File: rtl/gradient_magnitude_direction_pkg.sv
// Shared types and constants for the gradient magnitude/direction stage.
package gradient_pkg;

    // Quantised gradient direction sectors
    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_D  = 2'd1,
        DIR_V  = 2'd2,
        DIR_AD = 2'd3
    } dir_e;

    // Field positions inside the packed Gx/Gy vector
    localparam int GX_LSB = 0;
    localparam int GY_LSB = 16;

    // tan(22.5 deg) ~= TAN_NUM / TAN_DEN
    localparam int TAN_NUM = 53;
    localparam int TAN_DEN = 128;

endpackage

// File: rtl/gradient_magnitude_direction_if.sv
// Pixel-stream bundle between the Gx/Gy stage, this block and its consumers.
interface gradient_magnitude_direction_if
    import gradient_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 22
);
    logic [31:0]           i_Gx_Gy_vector;
    logic                  i_data_valid;
    logic                  i_start_of_frame;
    logic [DATA_WIDTH-1:0] o_magnitude;
    dir_e                  o_direction;
    logic                  o_edge;
    logic                  o_data_valid;
    logic                  o_start_of_frame;
    logic [DATA_WIDTH-1:0] o_frame_max;
    logic [CNT_W-1:0]      o_frame_pixels;
    logic                  o_frame_done;

    modport master (
        output i_Gx_Gy_vector, i_data_valid, i_start_of_frame,
        input  o_magnitude, o_direction, o_edge, o_data_valid, o_start_of_frame,
        input  o_frame_max, o_frame_pixels, o_frame_done
    );

    modport slave (
        input  i_Gx_Gy_vector, i_data_valid, i_start_of_frame,
        output o_magnitude, o_direction, o_edge, o_data_valid, o_start_of_frame,
        output o_frame_max, o_frame_pixels, o_frame_done
    );
endinterface

// File: rtl/gradient_magnitude_direction_frame_stats.sv
// Per-frame peak magnitude and valid-pixel count, published at each frame boundary.
module gradient_frame_stats
    import gradient_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 22
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_mag,
    output logic [DATA_WIDTH-1:0] o_frame_max,
    output logic [CNT_W-1:0]      o_frame_pixels,
    output logic                  o_frame_done
);

    logic                  frame_active;
    logic [DATA_WIDTH-1:0] run_max;
    logic [CNT_W-1:0]      run_cnt;

    // Track the open frame; close and publish it when the next SOF arrives
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            frame_active   <= 1'b0;
            run_max        <= '0;
            run_cnt        <= '0;
            o_frame_max    <= '0;
            o_frame_pixels <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_valid && i_sof) begin
                if (frame_active) begin
                    o_frame_max    <= run_max;
                    o_frame_pixels <= run_cnt;
                    o_frame_done   <= 1'b1;
                end
                run_max      <= i_mag;
                run_cnt      <= CNT_W'(1);
                frame_active <= 1'b1;
            end else if (i_valid && frame_active) begin
                if (i_mag > run_max) begin
                    run_max <= i_mag;
                end
                if (run_cnt != '1) begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gradient_magnitude_direction.sv
// Gx/Gy unpack -> saturated L1 magnitude, 4-sector direction, edge flag (3 stages).
module gradient_magnitude_direction
    import gradient_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAG_SHIFT  = 2,
    parameter int THRESHOLD  = 32,
    parameter int CNT_W      = 22
) (
    input  logic                          i_clk,
    input  logic                          i_areset,
    gradient_magnitude_direction_if.slave bus
);

    localparam int FW = DATA_WIDTH + 5;   // signed field width
    localparam int AW = DATA_WIDTH + 4;   // absolute value width
    localparam int PW = AW + 7;           // tangent product width
    localparam logic [AW:0]           MAG_MAX = (AW+1)'((1 << DATA_WIDTH) - 1);
    localparam logic [DATA_WIDTH-1:0] THR     = DATA_WIDTH'(THRESHOLD);

    logic signed [FW-1:0] gx, gy;
    logic [AW-1:0]        a_next, b_next;
    logic                 unused_vec_bits;

    assign gx = bus.i_Gx_Gy_vector[GX_LSB +: FW];
    assign gy = bus.i_Gx_Gy_vector[GY_LSB +: FW];
    assign a_next = gx[FW-1] ? AW'(-gx) : AW'(gx);
    assign b_next = gy[FW-1] ? AW'(-gy) : AW'(gy);
    assign unused_vec_bits = ^{bus.i_Gx_Gy_vector[31:GY_LSB+FW],
                               bus.i_Gx_Gy_vector[GY_LSB-1:GX_LSB+FW]};

    logic [AW-1:0] a1, b1;
    logic          sx1, sy1, val1, sof1;

    // Stage 1: absolute values and signs
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            a1   <= '0;
            b1   <= '0;
            sx1  <= 1'b0;
            sy1  <= 1'b0;
            val1 <= 1'b0;
            sof1 <= 1'b0;
        end else begin
            a1   <= a_next;
            b1   <= b_next;
            sx1  <= gx[FW-1];
            sy1  <= gy[FW-1];
            val1 <= bus.i_data_valid;
            sof1 <= bus.i_start_of_frame & bus.i_data_valid;
        end
    end

    logic [PW-1:0] a_den, a_num, b_den, b_num;
    logic [AW:0]   s2;
    logic          hz2, vt2, sx2, sy2, val2, sof2;

    assign a_den = PW'(a1) * PW'(TAN_DEN);
    assign a_num = PW'(a1) * PW'(TAN_NUM);
    assign b_den = PW'(b1) * PW'(TAN_DEN);
    assign b_num = PW'(b1) * PW'(TAN_NUM);

    // Stage 2: L1 sum and 22.5-degree sector comparisons
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            s2   <= '0;
            hz2  <= 1'b0;
            vt2  <= 1'b0;
            sx2  <= 1'b0;
            sy2  <= 1'b0;
            val2 <= 1'b0;
            sof2 <= 1'b0;
        end else begin
            s2   <= (AW+1)'(a1) + (AW+1)'(b1);
            hz2  <= (b_den < a_num);
            vt2  <= (a_den < b_num);
            sx2  <= sx1;
            sy2  <= sy1;
            val2 <= val1;
            sof2 <= sof1;
        end
    end

    logic [AW:0]           sh;
    logic [DATA_WIDTH-1:0] mag_next;
    dir_e                  dir_next;

    assign sh       = s2 >> MAG_SHIFT;
    assign mag_next = (sh > MAG_MAX) ? '1 : sh[DATA_WIDTH-1:0];

    // Direction sector from the stage-2 comparison flags
    always_comb begin
        dir_next = DIR_H;
        if (s2 == '0) begin
            dir_next = DIR_H;
        end else if (hz2) begin
            dir_next = DIR_H;
        end else if (vt2) begin
            dir_next = DIR_V;
        end else if (sx2 == sy2) begin
            dir_next = DIR_D;
        end else begin
            dir_next = DIR_AD;
        end
    end

    // Stage 3: registered pixel outputs
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            bus.o_magnitude      <= '0;
            bus.o_direction      <= DIR_H;
            bus.o_edge           <= 1'b0;
            bus.o_data_valid     <= 1'b0;
            bus.o_start_of_frame <= 1'b0;
        end else begin
            bus.o_magnitude      <= mag_next;
            bus.o_direction      <= dir_next;
            bus.o_edge           <= (mag_next >= THR);
            bus.o_data_valid     <= val2;
            bus.o_start_of_frame <= sof2;
        end
    end

    // Statistics register on the same edge as stage 3, so o_frame_done lines up with o_start_of_frame
    gradient_frame_stats #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_stats (
        .i_clk          (i_clk),
        .i_areset       (i_areset),
        .i_valid        (val2),
        .i_sof          (sof2),
        .i_mag          (mag_next),
        .o_frame_max    (bus.o_frame_max),
        .o_frame_pixels (bus.o_frame_pixels),
        .o_frame_done   (bus.o_frame_done)
    );

endmodule

// File: doc/gradient_magnitude_direction.md
# gradient_magnitude_direction

Consumer of the packed Gx/Gy vector produced by the 5x5 Prewitt gradient stage. Unpacks the two signed gradient fields and computes a saturated L1 magnitude, a 4-sector quantised direction and an edge flag in a 3-stage pipeline. Also accumulates per-frame statistics (peak magnitude, pixel count) and publishes them at each frame boundary. Sits directly downstream of the Gx/Gy stage and feeds non-maximum suppression and thresholding.

## Interface
- DATA_WIDTH, 8, pixel width; Gx/Gy fields are DATA_WIDTH+5 bits signed
- MAG_SHIFT, 2, right shift applied to the L1 magnitude before saturation
- THRESHOLD, 32, o_edge asserted when shifted, saturated magnitude >= THRESHOLD
- CNT_W, 22, width of the frame pixel counter
- i_clk  in  1  clock; one clock domain, all logic on rising edge
- i_areset  in  1  asynchronous, active-high reset
- i_Gx_Gy_vector  in  32  Gx in [DATA_WIDTH+4:0], Gy in [DATA_WIDTH+20:16], two's complement; other bits ignored
- i_data_valid  in  1  vector valid this cycle
- i_start_of_frame  in  1  first pixel of frame; honoured only with i_data_valid
- o_magnitude  out  DATA_WIDTH  saturated (|Gx|+|Gy|) >> MAG_SHIFT
- o_direction  out  2  0 horizontal gradient, 1 diagonal (same signs), 2 vertical, 3 anti-diagonal
- o_edge  out  1  o_magnitude >= THRESHOLD
- o_data_valid  out  1  outputs valid
- o_start_of_frame  out  1  delayed, valid-qualified SOF
- o_frame_max  out  DATA_WIDTH  peak o_magnitude of the previous complete frame
- o_frame_pixels  out  CNT_W  valid-pixel count of the previous complete frame
- o_frame_done  out  1  single-cycle pulse when o_frame_max/o_frame_pixels update

## Operation
- Stage 1: sign-extend fields; register a=|Gx|, b=|Gy| (DATA_WIDTH+4 bits unsigned), sign bits sx, sy, valid, sof&valid.
- Stage 2: register s=a+b (DATA_WIDTH+5 bits), products 128*a, 53*a, 128*b, 53*b compared: h = (128*b < 53*a), v = (128*a < 53*b); carry sx, sy.
- Stage 3: m = s >> MAG_SHIFT, saturated to 2^DATA_WIDTH-1. Direction: s==0 -> 0; else h -> 0; else v -> 2; else sx==sy -> 1; else 3. Zero counts as non-negative.
- Pipeline registers advance every cycle; invalid cycles propagate valid=0, data contents don't-care but must not touch statistics.
- Statistics: frame_active flag, running max, running count. On stage-3 valid pixel with sof: if frame_active, latch max/count into o_frame_max/o_frame_pixels and pulse o_frame_done; then restart max=m, count=1, frame_active=1. On valid pixel without sof while frame_active: max=max(max,m), count+=1 saturating at 2^CNT_W-1. Valid pixels before first SOF are ignored.
- SOF without valid is discarded at input.

## Timing
- Latency 3 cycles input to o_magnitude/o_direction/o_edge/o_data_valid/o_start_of_frame; full throughput, one pixel per cycle, no backpressure.
- o_frame_done asserts on the same cycle as the o_start_of_frame that closes the frame; o_frame_max/o_frame_pixels change only on that cycle and hold otherwise.
- Reset values: all outputs 0; frame_active 0, pipeline valid bits 0, counters 0.
- Reset mid-frame: partial frame discarded; first SOF after reset produces no o_frame_done.
- Back-to-back SOFs (1-pixel frames): each closes previous frame with o_frame_pixels=1.

## Structure
- Package gradient_pkg: direction enum (DIR_H=0, DIR_D=1, DIR_V=2, DIR_AD=3), field LSB constants GX_LSB=0, GY_LSB=16, tangent constants TAN_NUM=53, TAN_DEN=128.
- Sub-module gradient_frame_stats: stage-3 statistics (frame_active, max, count, latch, done pulse); top holds stages 1-3 datapath.

## Test plan
- Vector 0x0000_0064 (Gx=100, Gy=0), valid, sof -> 3 cycles later o_magnitude=25, o_direction=0, o_edge=0, o_start_of_frame=1, o_frame_done=0.
- Vector 0x0028_1FD8 (Gx=-40, Gy=40) -> o_magnitude=20, o_direction=3; 0x1F38_0000 (Gy=-200) -> magnitude 50, direction 2, o_edge=1.
- Gx=Gy=3825 -> magnitude saturates to 255, direction 1, o_edge=1; vector 0 -> magnitude 0, direction 0.
- SOF+2 pixels (magnitudes 25,50,20 with gaps of invalid cycles), then SOF -> o_frame_done one cycle coinciding with o_start_of_frame, o_frame_pixels=3, o_frame_max=50; SOF without valid causes no event.
- Assert i_areset mid-frame, release, send SOF then SOF -> first SOF no o_frame_done, second gives o_frame_pixels=1; all outputs 0 during reset.
